vram_writer: RTL



---
 rtl/vram_writer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/vram_writer.sv
// Write-side front end for video memory: boot-time frame-buffer clear followed by
// single-pixel masked word writes into LPDDR controller port 4 (data first, then command).
module vram_writer #(
  parameter logic [29:0] VRAM_BASE = 30'h0000_0000,
  parameter logic [7:0]  CLEAR_RGB = 8'h00,
  parameter int          ROWS      = 192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        calib_done,
  output logic        clear_screen_done,
  output logic        pixel_wr_done,
  input  logic        pixel_en,
  input  logic [7:0]  pixel_rgb,
  input  logic [7:0]  pixel_x,
  input  logic [7:0]  pixel_y,
  output logic        mem_cmd_en,
  output logic [2:0]  mem_cmd_instr,
  output logic [5:0]  mem_cmd_bl,
  output logic [29:0] mem_cmd_byte_addr,
  input  logic        mem_cmd_empty,
  input  logic        mem_cmd_full,
  output logic        mem_wr_en,
  output logic [3:0]  mem_wr_mask,
  output logic [31:0] mem_wr_data,
  input  logic        mem_wr_full,
  input  logic        mem_wr_empty,
  input  logic [6:0]  mem_wr_count,
  input  logic        mem_wr_underrun,
  input  logic        mem_wr_error,
  output logic        wr_error
);

  // Each clear burst covers half a 256-byte row, so two bursts per visible row.
  localparam logic [8:0] LAST_BURST = 9'(ROWS * 2 - 1);
  localparam logic [8:0] ROW_LIMIT  = 9'(ROWS);

  typedef enum logic [2:0] {
    WAIT_CAL,
    CLR_DATA,
    CLR_CMD,
    IDLE,
    PIX_DATA,
    PIX_CMD
  } state_t;

  state_t      state, state_n;
  logic [8:0]  burst, burst_n;
  logic [4:0]  word, word_n;
  logic        done_n, ready_n, cmd_en_n, wr_en_n, err_n, load;
  logic [5:0]  bl_n;
  logic [29:0] addr_n;
  logic [3:0]  mask_n;
  logic [31:0] data_n;
  logic [7:0]  px_rgb, px_x, px_y;

  // Status/count inputs of the controller are not needed by this block.
  logic unused_inputs;
  assign unused_inputs = ^{mem_cmd_empty, mem_wr_empty, mem_wr_count};

  // Only writes are ever issued.
  assign mem_cmd_instr = 3'b000;

  // Byte-enable mask: 1 = byte not written, lane 0 is data[7:0].
  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    return ~(4'b0001 << lane);
  endfunction

  // Word-aligned address of pixel (x, y): one 256-byte row per y.
  function automatic logic [29:0] word_addr(input logic [7:0] x, input logic [7:0] y);
    return VRAM_BASE + {14'd0, y, x[7:2], 2'b00};
  endfunction

  // Address of clear burst b: 32 words = 128 bytes per burst.
  function automatic logic [29:0] burst_addr(input logic [8:0] b);
    return VRAM_BASE + {14'd0, b, 7'd0};
  endfunction

  // Next-state and next-output decode; outputs hold their value unless a push happens.
  always_comb begin
    state_n  = state;
    burst_n  = burst;
    word_n   = word;
    done_n   = clear_screen_done;
    ready_n  = pixel_wr_done;
    cmd_en_n = 1'b0;
    wr_en_n  = 1'b0;
    bl_n     = mem_cmd_bl;
    addr_n   = mem_cmd_byte_addr;
    mask_n   = mem_wr_mask;
    data_n   = mem_wr_data;
    load     = 1'b0;
    err_n    = wr_error | mem_wr_underrun | mem_wr_error;
    case (state)
      WAIT_CAL: begin
        if (calib_done) begin
          state_n = CLR_DATA;
          burst_n = '0;
          word_n  = '0;
        end
      end
      CLR_DATA: begin
        if (!mem_wr_full) begin
          wr_en_n = 1'b1;
          data_n  = {4{CLEAR_RGB}};
          mask_n  = 4'h0;
          word_n  = word + 5'd1;
          if (word == 5'd31) state_n = CLR_CMD;
        end
      end
      CLR_CMD: begin
        if (!mem_cmd_full) begin
          cmd_en_n = 1'b1;
          bl_n     = 6'd31;
          addr_n   = burst_addr(burst);
          if (burst == LAST_BURST) begin
            state_n = IDLE;
          end else begin
            burst_n = burst + 9'd1;
            state_n = CLR_DATA;
          end
        end
      end
      IDLE: begin
        // Ready (and clear-done) come up one cycle after entering IDLE; a request is
        // taken only while ready is visible, and the data push is attempted at once.
        if (pixel_wr_done && pixel_en) begin
          load    = 1'b1;
          ready_n = 1'b0;
          if ({1'b0, pixel_y} >= ROW_LIMIT) begin
            state_n = IDLE;
          end else if (!mem_wr_full) begin
            wr_en_n = 1'b1;
            data_n  = {4{pixel_rgb}};
            mask_n  = lane_mask(pixel_x[1:0]);
            state_n = PIX_CMD;
          end else begin
            state_n = PIX_DATA;
          end
        end else begin
          ready_n = 1'b1;
          done_n  = 1'b1;
        end
      end
      PIX_DATA: begin
        if (!mem_wr_full) begin
          wr_en_n = 1'b1;
          data_n  = {4{px_rgb}};
          mask_n  = lane_mask(px_x[1:0]);
          state_n = PIX_CMD;
        end
      end
      PIX_CMD: begin
        if (!mem_cmd_full) begin
          cmd_en_n = 1'b1;
          bl_n     = 6'd0;
          addr_n   = word_addr(px_x, px_y);
          state_n  = IDLE;
        end
      end
      default: state_n = WAIT_CAL;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= WAIT_CAL;
      burst             <= '0;
      word              <= '0;
      clear_screen_done <= 1'b0;
      pixel_wr_done     <= 1'b0;
      mem_cmd_en        <= 1'b0;
      mem_wr_en         <= 1'b0;
      mem_cmd_bl        <= '0;
      mem_cmd_byte_addr <= '0;
      mem_wr_mask       <= 4'hF;
      mem_wr_data       <= '0;
      wr_error          <= 1'b0;
    end else begin
      state             <= state_n;
      burst             <= burst_n;
      word              <= word_n;
      clear_screen_done <= done_n;
      pixel_wr_done     <= ready_n;
      mem_cmd_en        <= cmd_en_n;
      mem_wr_en         <= wr_en_n;
      mem_cmd_bl        <= bl_n;
      mem_cmd_byte_addr <= addr_n;
      mem_wr_mask       <= mask_n;
      mem_wr_data       <= data_n;
      wr_error          <= err_n;
    end
  end

  // Request capture; the source may change its inputs right after acceptance.
  always_ff @(posedge clk) begin
    if (load) begin
      px_rgb <= pixel_rgb;
      px_x   <= pixel_x;
      px_y   <= pixel_y;
    end
  end

endmodule
